controller: RTL and testbench
=============================

# controller

Control unit for the single-cycle ARM core. It decodes `Instr[31:12]` into the datapath's mux selects, ALU operation and write enables. It holds the architectural condition flags (N, Z, C, V) and evaluates the instruction's condition field against them, suppressing every state-changing effect of a failed instruction. It sits directly upstream of the datapath, and also drives the data-memory write enable.

## Interface
- No parameters.
- `clk` in 1: core clock, rising-edge.
- `reset` in 1: synchronous, active-high.
- `Instr` in 20: `Instr[31:12]`; cond `[31:28]`, op `[27:26]`, funct `[25:20]`, Rd `[15:12]`.
- `ALUFlags` in 4: from ALU, `{N,Z,C,V}` = `[3:0]`.
- `RegSrc` out 2: `[0]` RA1=R15, `[1]` RA2=Rd.
- `RegWrite` out 1: register-file write enable (condition-gated).
- `ImmSrc` out 2: 00 imm8 zero-extend, 01 imm12 zero-extend, 10 imm24 branch.
- `ALUSrcA` out 1: 1 = ALU A operand forced to 0.
- `ALUSrcB` out 1: 1 = ALU B operand is ExtImm.
- `ALUControl` out 2: 00 add, 01 sub, 10 and, 11 or.
- `MemWrite` out 1: data-memory write enable (condition-gated).
- `MemtoReg` out 1: result from ReadData.
- `PCSrc` out 1: next PC from Result (condition-gated).

## Operation
- **op=00, data processing.** Fields: I=`funct[5]`, cmd=`funct[4:1]`, S=`funct[0]`.
  - Decode: `ALUSrcB`=I, `ImmSrc`=00, `RegSrc`=00, RegW=1.
  - ALU op by cmd: 0100→00, 0010→01, 0000→10, 1100→11.
  - Any other cmd: RegW=0, `ALUControl`=00, flags not written.
- **op=01, memory.** L=`funct[0]`, U=`funct[3]`.
  - Decode: `ALUSrcB`=1, `ImmSrc`=01.
  - `ALUControl`: U=1→00, U=0→01.
  - LDR: RegW=1, `MemtoReg`=1, `RegSrc`=00.
  - STR: MemW=1, `RegSrc`=10.
- **op=10, branch.** `ALUSrcB`=1, `ImmSrc`=10, `RegSrc`=01, Branch=1, `ALUControl`=00.
- **op=11.** Undefined. All enables 0; all selects 0.
- **PC source.** PCS = Branch | (RegW & Rd==4'hF).
- **Flag write, data processing only.**
  - FlagW[1] (N,Z) = S & valid cmd.
  - FlagW[0] (C,V) = S & cmd ∈ {ADD, SUB}.
- **Condition evaluation.** CondEx is computed from cond and the *registered* flags:
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N.
  - 0110 VS V; 0111 VC !V; 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V.
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 → 0.
- **Output gating.**
  - `RegWrite`=RegW&CondEx, `MemWrite`=MemW&CondEx, `PCSrc`=PCS&CondEx.
  - Selects (`RegSrc`, `ImmSrc`, `ALUSrc*`, `ALUControl`, `MemtoReg`) are ungated.
- **Flag registers.** Two independently enabled registers: NZ and CV.
  - Written on the rising edge when FlagW bit & CondEx & !reset.
  - Captured value is `ALUFlags` of the same cycle.

## Timing
- All decode and gating is combinational, with zero-cycle latency from `Instr`/flags to outputs.
- Flags update on the clock edge that ends the instruction. The next instruction sees the new flags.
- A failed-condition S-instruction leaves both flag registers unchanged.
- ADDS/SUBS write both flag registers. ANDS/ORRS write NZ only, and C,V are held.
- **Reset.**
  - N, Z, C, V all load 0 at the first edge with `reset`=1.
  - While `reset`=1, `RegWrite`, `MemWrite` and `PCSrc` are forced 0 and no flags are written.
- **Reset mid-instruction.** The instruction in flight has no effect; flags still clear.
- **Rd=15 data-processing write with failed condition.** `PCSrc`=0, and the PC advances by 4 only.

## Configuration
- Macro: `CONTROLLER_MOV_EN`.
- **Defined.** cmd=1101 (MOV) decodes as follows:
  - RegW=1, `ALUSrcA`=1, `ALUControl`=00, so the result is 0+SrcB.
  - With S, MOVS writes NZ only.
- **Undefined.** cmd=1101 is an invalid cmd:
  - RegW=0, no flag write.
  - `ALUSrcA` is tied to 0 for all instructions.

## Test plan
- **Reset sequence.** Hold `reset`=1 for 2 cycles with `ALUFlags`=4'hF and an ADDS instruction → `RegWrite`/`MemWrite`/`PCSrc`=0 throughout; flags 0000 after release; BEQ then has `PCSrc`=0.
- **SUBS then BEQ.**
  - SUBS (cond 1110, cmd 0010, S=1) with `ALUFlags`=4'b0110 → `ALUControl`=01, `RegWrite`=1; next cycle flags NZCV=0110.
  - BEQ (cond 0000, op 10) → `PCSrc`=1, `ImmSrc`=10, `RegSrc`=01.
  - BNE → `PCSrc`=0.
- **Logical op preserves C,V.** With flags preset to C=1,V=1, ANDS with `ALUFlags`=4'b1000 → flags become 1011.
- **Failed condition.** Flags Z=0, then ADDEQ S=1, Rd=15 → `RegWrite`=0, `PCSrc`=0; flags unchanged the next cycle.
- **Memory ops.**
  - LDR U=1 → `MemtoReg`=1, `ALUSrcB`=1, `ImmSrc`=01, `ALUControl`=00, `RegWrite`=1.
  - STR U=0 → `MemWrite`=1, `RegSrc`=10, `ALUControl`=01, `RegWrite`=0.
- **MOV, both builds.** MOV R1,#5 (cmd 1101, I=1):
  - With `CONTROLLER_MOV_EN`: `ALUSrcA`=1, `RegWrite`=1.
  - Without it: `RegWrite`=0, `ALUSrcA`=0.
  - Op 11 in either build → all enables 0.

Source files
------------

// File: rtl/controller.sv
// -----------------------------------------------------------------------------
// controller
//
// Control unit for the single-cycle ARM core. Decodes Instr[31:12] into the
// datapath mux selects, the ALU operation and the write enables, keeps the
// architectural condition flags (N,Z,C,V) and evaluates the condition field
// of each instruction against them. A failed condition suppresses every
// state-changing effect (register write, memory write, PC redirect and flag
// update); the mux selects are left ungated because they are harmless.
//
// Optional feature macro: CONTROLLER_MOV_EN
//   defined   : cmd=1101 decodes as MOV (result = 0 + SrcB, MOVS writes NZ)
//   undefined : cmd=1101 is an invalid data-processing cmd, ALUSrcA is 0
//
// Ports
//   clk        in  1  core clock, rising edge
//   reset      in  1  synchronous, active-high
//   Instr      in 20  Instr[31:12]: cond[31:28] op[27:26] funct[25:20] Rd[15:12]
//   ALUFlags   in  4  {N,Z,C,V} from the ALU for the current instruction
//   RegSrc     out 2  [0] RA1 = R15, [1] RA2 = Rd
//   RegWrite   out 1  register-file write enable (condition-gated)
//   ImmSrc     out 2  00 imm8, 01 imm12, 10 imm24 branch
//   ALUSrcA    out 1  1 = ALU A operand forced to 0
//   ALUSrcB    out 1  1 = ALU B operand is ExtImm
//   ALUControl out 2  00 add, 01 sub, 10 and, 11 or
//   MemWrite   out 1  data-memory write enable (condition-gated)
//   MemtoReg   out 1  result taken from ReadData
//   PCSrc      out 1  next PC taken from Result (condition-gated)
// -----------------------------------------------------------------------------
module controller (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:12] Instr,
    input  logic [3:0]   ALUFlags,
    output logic [1:0]   RegSrc,
    output logic         RegWrite,
    output logic [1:0]   ImmSrc,
    output logic         ALUSrcA,
    output logic         ALUSrcB,
    output logic [1:0]   ALUControl,
    output logic         MemWrite,
    output logic         MemtoReg,
    output logic         PCSrc
);

    logic [3:0] w_cond;
    logic [1:0] w_op;
    logic [5:0] w_funct;
    logic [3:0] w_cmd;
    logic [3:0] w_rd;
    logic       w_sBit;

    assign w_cond  = Instr[31:28];
    assign w_op    = Instr[27:26];
    assign w_funct = Instr[25:20];
    assign w_cmd   = w_funct[4:1];
    assign w_sBit  = w_funct[0];
    assign w_rd    = Instr[15:12];

    // Rn only matters to the datapath's register file, not to control.
    logic w_unusedRn;
    assign w_unusedRn = ^Instr[19:16];

    // Architectural flags, split so logical ops can update NZ and hold CV.
    logic [1:0] r_flagsNZ;
    logic [1:0] r_flagsCV;

    logic [1:0] w_regSrc;
    logic [1:0] w_immSrc;
    logic       w_aluSrcA;
    logic       w_aluSrcB;
    logic [1:0] w_aluCtl;
    logic       w_memtoReg;
    logic       w_regW;
    logic       w_memW;
    logic       w_branch;
    logic [1:0] w_flagW;
    logic       w_pcs;
    logic       w_condEx;

    // Main decoder: everything starts at the "do nothing" value so op=11 and
    // unlisted cmds fall out as no-ops without extra branches.
    always_comb begin
        w_regSrc   = 2'b00;
        w_immSrc   = 2'b00;
        w_aluSrcA  = 1'b0;
        w_aluSrcB  = 1'b0;
        w_aluCtl   = 2'b00;
        w_memtoReg = 1'b0;
        w_regW     = 1'b0;
        w_memW     = 1'b0;
        w_branch   = 1'b0;
        w_flagW    = 2'b00;
        case (w_op)
            2'b00: begin
                w_aluSrcB = w_funct[5];
                w_regW    = 1'b1;
                case (w_cmd)
                    4'b0100: begin
                        w_aluCtl = 2'b00;
                        w_flagW  = {w_sBit, w_sBit};
                    end
                    4'b0010: begin
                        w_aluCtl = 2'b01;
                        w_flagW  = {w_sBit, w_sBit};
                    end
                    4'b0000: begin
                        w_aluCtl = 2'b10;
                        w_flagW  = {w_sBit, 1'b0};
                    end
                    4'b1100: begin
                        w_aluCtl = 2'b11;
                        w_flagW  = {w_sBit, 1'b0};
                    end
`ifdef CONTROLLER_MOV_EN
                    4'b1101: begin
                        w_aluSrcA = 1'b1;
                        w_aluCtl  = 2'b00;
                        w_flagW   = {w_sBit, 1'b0};
                    end
`endif
                    default: begin
                        w_regW = 1'b0;
                    end
                endcase
            end
            2'b01: begin
                w_aluSrcB = 1'b1;
                w_immSrc  = 2'b01;
                w_aluCtl  = w_funct[3] ? 2'b00 : 2'b01;
                if (w_funct[0]) begin
                    w_regW     = 1'b1;
                    w_memtoReg = 1'b1;
                end else begin
                    w_memW   = 1'b1;
                    w_regSrc = 2'b10;
                end
            end
            2'b10: begin
                w_aluSrcB = 1'b1;
                w_immSrc  = 2'b10;
                w_regSrc  = 2'b01;
                w_branch  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // A write to R15 is a jump, just like a branch.
    assign w_pcs = w_branch | (w_regW & (w_rd == 4'hF));

    // Condition check against the registered flags, never the live ALU flags.
    always_comb begin
        logic n, z, c, v;
        n = r_flagsNZ[1];
        z = r_flagsNZ[0];
        c = r_flagsCV[1];
        v = r_flagsCV[0];
        w_condEx = 1'b0;
        case (w_cond)
            4'b0000: w_condEx = z;
            4'b0001: w_condEx = ~z;
            4'b0010: w_condEx = c;
            4'b0011: w_condEx = ~c;
            4'b0100: w_condEx = n;
            4'b0101: w_condEx = ~n;
            4'b0110: w_condEx = v;
            4'b0111: w_condEx = ~v;
            4'b1000: w_condEx = c & ~z;
            4'b1001: w_condEx = ~c | z;
            4'b1010: w_condEx = (n == v);
            4'b1011: w_condEx = (n != v);
            4'b1100: w_condEx = ~z & (n == v);
            4'b1101: w_condEx = z | (n != v);
            4'b1110: w_condEx = 1'b1;
            default: w_condEx = 1'b0;
        endcase
    end

    // Flag registers: reset clears both; otherwise each half loads the ALU
    // flags of this cycle only when its enable is set and the condition held.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flagsNZ <= 2'b00;
            r_flagsCV <= 2'b00;
        end else begin
            if (w_flagW[1] && w_condEx) begin
                r_flagsNZ <= ALUFlags[3:2];
            end
            if (w_flagW[0] && w_condEx) begin
                r_flagsCV <= ALUFlags[1:0];
            end
        end
    end

    // State-changing enables are gated by the condition and held off during
    // reset; the selects pass straight through.
    assign RegWrite   = w_regW & w_condEx & ~reset;
    assign MemWrite   = w_memW & w_condEx & ~reset;
    assign PCSrc      = w_pcs  & w_condEx & ~reset;
    assign RegSrc     = w_regSrc;
    assign ImmSrc     = w_immSrc;
    assign ALUSrcA    = w_aluSrcA;
    assign ALUSrcB    = w_aluSrcB;
    assign ALUControl = w_aluCtl;
    assign MemtoReg   = w_memtoReg;

endmodule

// File: tb/tb_controller.sv
// -----------------------------------------------------------------------------
// tb_controller
//
// Directed bench for the ARM control unit. The flag registers are not ports,
// so their contents are observed by stepping a branch through all sixteen
// condition codes and comparing the PCSrc pattern with a hand-computed mask
// (bit i = condition i passes).
// -----------------------------------------------------------------------------
module tb_controller;

    logic        clk;
    logic        reset;
    logic [19:0] instr;
    logic [3:0]  aluFlags;
    logic [1:0]  regSrc;
    logic        regWrite;
    logic [1:0]  immSrc;
    logic        aluSrcA;
    logic        aluSrcB;
    logic [1:0]  aluControl;
    logic        memWrite;
    logic        memtoReg;
    logic        pcSrc;

    int checkCount = 0;
    int errorCount = 0;

    controller dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (instr),
        .ALUFlags   (aluFlags),
        .RegSrc     (regSrc),
        .RegWrite   (regWrite),
        .ImmSrc     (immSrc),
        .ALUSrcA    (aluSrcA),
        .ALUSrcB    (aluSrcB),
        .ALUControl (aluControl),
        .MemWrite   (memWrite),
        .MemtoReg   (memtoReg),
        .PCSrc      (pcSrc)
    );

    // Clock: rising edges at 5, 15, 25 ...; the bench drives and samples
    // around the falling edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instr[31:12] = {cond, op, funct, Rn, Rd}
    function automatic logic [19:0] mkInstr(input logic [3:0] cond, input logic [1:0] op,
                                            input logic [5:0] funct, input logic [3:0] rd);
        return {cond, op, funct, 4'h0, rd};
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Apply one instruction for one cycle: drive just after the falling edge,
    // let the combinational outputs settle, return before the rising edge.
    task automatic applyStimulus(input logic [19:0] ins, input logic [3:0] flg, input logic rst);
        @(negedge clk);
        instr    = ins;
        aluFlags = flg;
        reset    = rst;
        #1;
    endtask

    // Walk a branch through every condition code; one instruction per cycle,
    // none of which writes flags.
    task automatic probeFlags(input string tag, input logic [15:0] mask);
        logic [15:0] seen;
        seen = 16'h0;
        for (int c = 0; c < 16; c++) begin
            applyStimulus(mkInstr(c[3:0], 2'b10, 6'b100000, 4'h0), 4'h0, 1'b0);
            seen[c] = pcSrc;
        end
        checkOutput(tag, seen, mask);
    endtask

    localparam logic [3:0] AL = 4'hE;
    localparam logic [3:0] EQ = 4'h0;

    initial begin
        logic [19:0] addsIns;
        addsIns  = mkInstr(AL, 2'b00, 6'b001001, 4'h1);
        reset    = 1'b1;
        instr    = addsIns;
        aluFlags = 4'hF;

        // Reset held two cycles with an ADDS in flight and all ALU flags set.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(addsIns, 4'hF, 1'b1);
            checkOutput($sformatf("rst%0d_enables", i), {13'h0, regWrite, memWrite, pcSrc}, 16'h0);
        end

        // After reset: flags 0000. BEQ must not be taken.
        applyStimulus(mkInstr(EQ, 2'b10, 6'b100000, 4'h0), 4'h0, 1'b0);
        checkOutput("postrst_beq_pcsrc", {15'h0, pcSrc}, 16'h0);
        probeFlags("flags_after_reset", 16'h56AA);

        // SUBS R1 with ALU flags 0110.
        applyStimulus(mkInstr(AL, 2'b00, 6'b000101, 4'h1), 4'b0110, 1'b0);
        checkOutput("subs_aluctl", {14'h0, aluControl}, 16'h1);
        checkOutput("subs_enables", {13'h0, regWrite, memWrite, pcSrc}, 16'b100);
        checkOutput("subs_alusrcb", {15'h0, aluSrcB}, 16'h0);

        // BEQ now taken (Z=1), with branch selects.
        applyStimulus(mkInstr(EQ, 2'b10, 6'b100000, 4'h0), 4'h0, 1'b0);
        checkOutput("beq_pcsrc", {15'h0, pcSrc}, 16'h1);
        checkOutput("beq_immsrc", {14'h0, immSrc}, 16'h2);
        checkOutput("beq_regsrc", {14'h0, regSrc}, 16'h1);
        checkOutput("beq_misc", {12'h0, aluSrcB, aluControl, regWrite}, 16'b1000);
        applyStimulus(mkInstr(4'h1, 2'b10, 6'b100000, 4'h0), 4'h0, 1'b0);
        checkOutput("bne_pcsrc", {15'h0, pcSrc}, 16'h0);
        probeFlags("flags_after_subs", 16'h66A5);

        // ADDS with ALU flags 0011 presets C=1,V=1 (and clears N,Z).
        applyStimulus(addsIns, 4'b0011, 1'b0);
        checkOutput("adds_aluctl", {14'h0, aluControl}, 16'h0);
        probeFlags("flags_after_adds", 16'h6966);

        // ANDS with ALU flags 1000: NZ updated, CV held -> 1011.
        applyStimulus(mkInstr(AL, 2'b00, 6'b000001, 4'h2), 4'b1000, 1'b0);
        checkOutput("ands_aluctl", {14'h0, aluControl}, 16'h2);
        probeFlags("flags_after_ands", 16'h5556);

        // ORR (no S) with Rd=15 under AL: a jump, flags untouched.
        applyStimulus(mkInstr(AL, 2'b00, 6'b011000, 4'hF), 4'b0100, 1'b0);
        checkOutput("orr_pc_aluctl", {14'h0, aluControl}, 16'h3);
        checkOutput("orr_pc_enables", {13'h0, regWrite, memWrite, pcSrc}, 16'b101);

        // ADDEQ S=1 Rd=15 with Z=0: nothing happens, flags unchanged.
        applyStimulus(mkInstr(EQ, 2'b00, 6'b001001, 4'hF), 4'b0100, 1'b0);
        checkOutput("addeq_fail_enables", {13'h0, regWrite, memWrite, pcSrc}, 16'h0);
        probeFlags("flags_after_failed", 16'h5556);

        // Invalid cmd 0001 with S=1: no register write, no flag write.
        applyStimulus(mkInstr(AL, 2'b00, 6'b000011, 4'h1), 4'b0100, 1'b0);
        checkOutput("badcmd_enables", {13'h0, regWrite, memWrite, pcSrc}, 16'h0);
        checkOutput("badcmd_aluctl", {14'h0, aluControl}, 16'h0);
        probeFlags("flags_after_badcmd", 16'h5556);

        // LDR U=1.
        applyStimulus(mkInstr(AL, 2'b01, 6'b011001, 4'h3), 4'h0, 1'b0);
        checkOutput("ldr_sel", {10'h0, memtoReg, aluSrcB, immSrc, aluControl}, 16'b110100);
        checkOutput("ldr_enables", {13'h0, regWrite, memWrite, pcSrc}, 16'b100);
        checkOutput("ldr_regsrc", {14'h0, regSrc}, 16'h0);

        // STR U=0.
        applyStimulus(mkInstr(AL, 2'b01, 6'b010000, 4'h3), 4'h0, 1'b0);
        checkOutput("str_enables", {13'h0, regWrite, memWrite, pcSrc}, 16'b010);
        checkOutput("str_regsrc", {14'h0, regSrc}, 16'h2);
        checkOutput("str_aluctl", {14'h0, aluControl}, 16'h1);

        // STREQ with Z=0: memory write suppressed.
        applyStimulus(mkInstr(EQ, 2'b01, 6'b010000, 4'h3), 4'h0, 1'b0);
        checkOutput("streq_fail_memw", {15'h0, memWrite}, 16'h0);

        // MOV R1,#5 (cmd 1101, I=1).
        applyStimulus(mkInstr(AL, 2'b00, 6'b111010, 4'h1), 4'h0, 1'b0);
`ifdef CONTROLLER_MOV_EN
        checkOutput("mov_srca", {15'h0, aluSrcA}, 16'h1);
        checkOutput("mov_regwrite", {15'h0, regWrite}, 16'h1);
        checkOutput("mov_aluctl", {14'h0, aluControl}, 16'h0);
`else
        checkOutput("mov_srca", {15'h0, aluSrcA}, 16'h0);
        checkOutput("mov_regwrite", {15'h0, regWrite}, 16'h0);
`endif
        checkOutput("mov_srcb", {15'h0, aluSrcB}, 16'h1);

        // op=11: all enables and selects zero.
        applyStimulus(mkInstr(AL, 2'b11, 6'b111111, 4'hF), 4'hF, 1'b0);
        checkOutput("op11_enables", {13'h0, regWrite, memWrite, pcSrc}, 16'h0);
        checkOutput("op11_selects",
                    {6'h0, regSrc, immSrc, aluSrcA, aluSrcB, aluControl, memtoReg, 1'b0}, 16'h0);

        // Reset arriving mid-instruction: ADDS suppressed, flags cleared.
        applyStimulus(addsIns, 4'b0100, 1'b1);
        checkOutput("midrst_enables", {13'h0, regWrite, memWrite, pcSrc}, 16'h0);
        probeFlags("flags_after_midrst", 16'h56AA);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
